frame_scheduler: RTL and testbench

- Per-frame sequencer around world_drawer.
- On each frame tick it clears the back framebuffer, then starts world_drawer and waits for done.
- It then applies at most one pending block edit (break or place) to world memory using the drawer's looked_at_cube/looked_at_normal, and finally requests a buffer swap.
- It owns the world-memory port and muxes it to the drawer only while drawing.

---
 rtl/world_pkg.sv | 34 +++
 rtl/free_slot_scanner.sv | 92 +++++++++
 rtl/frame_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_frame_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/world_pkg.sv
// Shared types and constants for the frame scheduler and its free-slot scanner.
package world_pkg;

    // Each stored coordinate is half of the drawer coordinate width.
    localparam int COORD_HALF = 16;

    // One world memory entry: {valid, x, y, z}.
    typedef struct packed {
        logic                  valid;
        logic [COORD_HALF-1:0] x;
        logic [COORD_HALF-1:0] y;
        logic [COORD_HALF-1:0] z;
    } world_entry_t;

    // Scheduler phases, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DRAW,
        EDIT_RD,
        EDIT_SCAN,
        EDIT_WR,
        SWAP
    } sched_state_e;

    // "No cube targeted" marker; slice to the world address width.
    localparam logic [31:0] NO_CUBE = '1;

    // Pixel count of one framebuffer.
    function automatic int fb_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/free_slot_scanner.sv
// Walks world addresses 0..WORLD_SIZE-1, one read issued per cycle, and
// reports the first entry whose valid bit is clear. Returned data is matched
// to its address through a READ_LATENCY-deep tag pipeline.
module free_slot_scanner #(
    parameter int WORLD_SIZE   = 100,
    parameter int WORLD_BITS   = 7,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_i,
    input  logic                  valid_bit_i,
    output logic [WORLD_BITS-1:0] addr_o,
    output logic                  done_o,
    output logic                  found_o,
    output logic [WORLD_BITS-1:0] slot_o
);

    localparam logic [WORLD_BITS-1:0] LAST = WORLD_BITS'(WORLD_SIZE - 1);

    logic                    active_q;
    logic                    issuing_q;
    logic [WORLD_BITS-1:0]   issue_q;
    logic [READ_LATENCY-1:0] tag_v_q;
    logic [WORLD_BITS-1:0]   tag_a_q [READ_LATENCY];
    logic                    done_q;
    logic                    found_q;
    logic [WORLD_BITS-1:0]   slot_q;

    logic                    ret_v;
    logic [WORLD_BITS-1:0]   ret_a;

    assign ret_v   = active_q && tag_v_q[READ_LATENCY-1];
    assign ret_a   = tag_a_q[READ_LATENCY-1];
    assign addr_o  = issue_q;
    assign done_o  = done_q;
    assign found_o = found_q;
    assign slot_o  = slot_q;

    // Issue addresses, track which reads are in flight, and judge returned entries.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active_q  <= 1'b0;
            issuing_q <= 1'b0;
            issue_q   <= '0;
            tag_v_q   <= '0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            slot_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            tag_v_q <= (tag_v_q << 1) | READ_LATENCY'(issuing_q);
            if (start_i) begin
                active_q  <= 1'b1;
                issuing_q <= 1'b1;
                issue_q   <= '0;
                tag_v_q   <= '0;
                found_q   <= 1'b0;
            end else if (active_q) begin
                if (issuing_q) begin
                    issue_q <= issue_q + 1'b1;
                    if (issue_q == LAST) issuing_q <= 1'b0;
                end
                if (ret_v) begin
                    if (!valid_bit_i) begin
                        found_q   <= 1'b1;
                        slot_q    <= ret_a;
                        done_q    <= 1'b1;
                        active_q  <= 1'b0;
                        issuing_q <= 1'b0;
                        tag_v_q   <= '0;
                    end else if (ret_a == LAST) begin
                        found_q  <= 1'b0;
                        done_q   <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Address side of the tag pipeline, shifted alongside tag_v_q.
    // NOTE: this pipeline holds only data qualified by tag_v_q, so it is left
    // without reset; only control state needs a known value.
    always_ff @(posedge clk_in) begin
        tag_a_q[0] <= issue_q;
        for (int i = 1; i < READ_LATENCY; i++) tag_a_q[i] <= tag_a_q[i-1];
    end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer around world_drawer: clear back buffer, draw, apply at
// most one pending block edit, then request a buffer swap. Owns the world
// memory port and lends it to the drawer only during DRAW.
// Optional: define FRAME_STATS_EN to count cycles per frame on frame_cycles.
module frame_scheduler
    import world_pkg::*;
#(
    parameter int COORD_WIDTH  = 32,
    parameter int FB_WIDTH     = 320,
    parameter int FB_HEIGHT    = 180,
    parameter int WORLD_SIZE   = 100,
    parameter int WORLD_BITS   = 7,
    parameter int NORMAL_WIDTH = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                                             clk_in,
    input  logic                                             rst_n_in,
    input  logic                                             frame_tick,
    input  logic                                             break_req,
    input  logic                                             place_req,
    output logic                                             drawer_start,
    input  logic                                             drawer_done,
    input  logic [WORLD_BITS-1:0]                            drawer_addr,
    input  logic [WORLD_BITS-1:0]                            looked_at_cube,
    input  logic [3*NORMAL_WIDTH-1:0]                        looked_at_normal,
    output logic [WORLD_BITS-1:0]                            world_addr,
    output logic [3*COORD_WIDTH/2:0]                         world_wdata,
    output logic                                             world_we,
    input  logic [3*COORD_WIDTH/2:0]                         world_rdata,
    output logic [$clog2(fb_pixels(FB_WIDTH, FB_HEIGHT))-1:0] fb_clear_addr,
    output logic                                             fb_clear_we,
    output logic                                             fb_swap,
    output logic                                             busy,
    output logic                                             edit_fail,
    output logic [31:0]                                      frame_cycles
);

    localparam int HALF  = COORD_WIDTH / 2;
    localparam int NW    = NORMAL_WIDTH;
    localparam int FB_AW = $clog2(fb_pixels(FB_WIDTH, FB_HEIGHT));
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(fb_pixels(FB_WIDTH, FB_HEIGHT) - 1);

    sched_state_e          state_q, state_d;
    logic [FB_AW-1:0]      fb_addr_q, fb_addr_d;
    logic                  pend_break_q, pend_break_d;
    logic                  pend_place_q, pend_place_d;
    logic [WORLD_BITS-1:0] own_addr_q, own_addr_d;
    logic [3*NW-1:0]       normal_q, normal_d;
    logic [3*HALF:0]       wdata_q, wdata_d;
    logic [3*HALF-1:0]     new_q, new_d;
    logic [LAT_W-1:0]      wait_q, wait_d;

    logic                  any_break, any_place, has_target;
    logic                  scan_start, scan_done, scan_found;
    logic [WORLD_BITS-1:0] scan_addr, scan_slot;
    logic [HALF-1:0]       nx, ny, nz;
    logic [3*HALF-1:0]     moved;

    assign any_break  = pend_break_q | break_req;
    assign any_place  = pend_place_q | place_req;
    assign has_target = (looked_at_cube != NO_CUBE[WORLD_BITS-1:0]);

    // Target cube shifted by the sign-extended face normal, wrapping at 2^16.
    assign nx    = {{(HALF-NW){normal_q[3*NW-1]}}, normal_q[3*NW-1:2*NW]};
    assign ny    = {{(HALF-NW){normal_q[2*NW-1]}}, normal_q[2*NW-1:NW]};
    assign nz    = {{(HALF-NW){normal_q[NW-1]}},   normal_q[NW-1:0]};
    assign moved = {world_rdata[3*HALF-1:2*HALF] + nx,
                    world_rdata[2*HALF-1:HALF]   + ny,
                    world_rdata[HALF-1:0]        + nz};

    assign fb_clear_addr = fb_addr_q;
    assign world_wdata   = wdata_q;
    assign busy          = (state_q != IDLE);

    free_slot_scanner #(
        .WORLD_SIZE  (WORLD_SIZE),
        .WORLD_BITS  (WORLD_BITS),
        .READ_LATENCY(READ_LATENCY)
    ) u_scanner (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .start_i    (scan_start),
        .valid_bit_i(world_rdata[3*HALF]),
        .addr_o     (scan_addr),
        .done_o     (scan_done),
        .found_o    (scan_found),
        .slot_o     (scan_slot)
    );

    // Next-state, edit bookkeeping and per-state outputs.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        fb_addr_d    = fb_addr_q;
        pend_break_d = any_break;
        pend_place_d = any_place;
        own_addr_d   = own_addr_q;
        normal_d     = normal_q;
        wdata_d      = wdata_q;
        new_d        = new_q;
        wait_d       = wait_q;
        drawer_start = 1'b0;
        fb_clear_we  = 1'b0;
        world_we     = 1'b0;
        fb_swap      = 1'b0;
        edit_fail    = 1'b0;
        scan_start   = 1'b0;
        world_addr   = own_addr_q;

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d   = CLEAR;
                    fb_addr_d = '0;
                end
            end
            CLEAR: begin
                fb_clear_we = 1'b1;
                if (fb_addr_q == FB_LAST) begin
                    fb_addr_d    = '0;
                    drawer_start = 1'b1;
                    state_d      = DRAW;
                end else begin
                    fb_addr_d = fb_addr_q + 1'b1;
                end
            end
            DRAW: begin
                world_addr = drawer_addr;
                if (drawer_done) begin
                    // Edits are consumed here whether or not a target exists.
                    pend_break_d = 1'b0;
                    pend_place_d = 1'b0;
                    state_d      = SWAP;
                    if (has_target && (any_break || any_place)) begin
                        own_addr_d = looked_at_cube;
                        normal_d   = looked_at_normal;
                        if (any_break) begin
                            wdata_d = '0;
                            state_d = EDIT_WR;
                        end else begin
                            wait_d  = '0;
                            state_d = EDIT_RD;
                        end
                    end
                end
            end
            EDIT_RD: begin
                if (wait_q == LAT_W'(READ_LATENCY)) begin
                    new_d      = moved;
                    scan_start = 1'b1;
                    state_d    = EDIT_SCAN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            EDIT_SCAN: begin
                world_addr = scan_addr;
                if (scan_done) begin
                    if (scan_found) begin
                        own_addr_d = scan_slot;
                        wdata_d    = {1'b1, new_q};
                        state_d    = EDIT_WR;
                    end else begin
                        edit_fail = 1'b1;
                        state_d   = SWAP;
                    end
                end
            end
            EDIT_WR: begin
                world_we = 1'b1;
                state_d  = SWAP;
            end
            SWAP: begin
                fb_swap = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            fb_addr_q    <= '0;
            pend_break_q <= 1'b0;
            pend_place_q <= 1'b0;
            own_addr_q   <= '0;
            normal_q     <= '0;
            wdata_q      <= '0;
            new_q        <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            fb_addr_q    <= fb_addr_d;
            pend_break_q <= pend_break_d;
            pend_place_q <= pend_place_d;
            own_addr_q   <= own_addr_d;
            normal_q     <= normal_d;
            wdata_q      <= wdata_d;
            new_q        <= new_d;
            wait_q       <= wait_d;
        end
    end

`ifdef FRAME_STATS_EN
    logic [31:0] cyc_q;
    logic [31:0] frame_cycles_q;
    logic [31:0] cyc_inc;

    assign cyc_inc      = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
    assign frame_cycles = frame_cycles_q;

    // Count non-idle cycles; publish the inclusive total on the swap cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cyc_q          <= '0;
            frame_cycles_q <= '0;
        end else begin
            cyc_q <= (state_q == IDLE) ? '0 : cyc_inc;
            if (state_q == SWAP) frame_cycles_q <= cyc_inc;
        end
    end
`else
    assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler with a 4x4 framebuffer and a
// READ_LATENCY-deep world memory model.
module tb_frame_scheduler;
    import world_pkg::*;

    localparam int CW  = 32;
    localparam int FBW = 4;
    localparam int FBH = 4;
    localparam int WS  = 100;
    localparam int WB  = 7;
    localparam int NW  = 2;
    localparam int RL  = 2;
    localparam int EW  = 3*CW/2 + 1;
    localparam int FBA = $clog2(FBW*FBH);

    logic            clk_in, rst_n_in;
    logic            frame_tick, break_req, place_req, drawer_done;
    logic            drawer_start, world_we, fb_clear_we, fb_swap, busy, edit_fail;
    logic [WB-1:0]   drawer_addr, looked_at_cube, world_addr;
    logic [3*NW-1:0] looked_at_normal;
    logic [EW-1:0]   world_wdata, world_rdata;
    logic [FBA-1:0]  fb_clear_addr;
    logic [31:0]     frame_cycles;

    frame_scheduler #(
        .COORD_WIDTH(CW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .WORLD_SIZE(WS),
        .WORLD_BITS(WB), .NORMAL_WIDTH(NW), .READ_LATENCY(RL)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_tick(frame_tick),
        .break_req(break_req), .place_req(place_req), .drawer_start(drawer_start),
        .drawer_done(drawer_done), .drawer_addr(drawer_addr),
        .looked_at_cube(looked_at_cube), .looked_at_normal(looked_at_normal),
        .world_addr(world_addr), .world_wdata(world_wdata), .world_we(world_we),
        .world_rdata(world_rdata), .fb_clear_addr(fb_clear_addr),
        .fb_clear_we(fb_clear_we), .fb_swap(fb_swap), .busy(busy),
        .edit_fail(edit_fail), .frame_cycles(frame_cycles)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- world memory model ----------------
    logic [EW-1:0] mem [WS];
    logic [EW-1:0] img [WS];
    logic          load;
    logic [WB-1:0] ra1, ra2;

    always @(posedge clk_in) begin
        if (load) begin
            for (int i = 0; i < WS; i++) mem[i] <= img[i];
        end else if (world_we && int'(world_addr) < WS) begin
            mem[world_addr] <= world_wdata;
        end
        ra1 <= world_addr;
        ra2 <= ra1;
    end
    assign world_rdata = (int'(ra2) < WS) ? mem[ra2] : '0;

    function automatic logic [EW-1:0] mk(input logic v, input int x, input int y, input int z);
        world_entry_t e;
        e.valid = v;
        e.x = 16'(x);
        e.y = 16'(y);
        e.z = 16'(z);
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    typedef enum logic [1:0] {EV_START, EV_WRITE, EV_FAIL, EV_SWAP} ev_kind_e;
    typedef struct {
        ev_kind_e      kind;
        logic [WB-1:0] addr;
        logic [EW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;
    int  run_len = 0;
    int  last_len = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_e k, input logic [WB-1:0] a, input logic [EW-1:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [WB-1:0] a, input logic [EW-1:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 64'(k), 64'hDEAD);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 64'(k), 64'(e.kind));
        if (k == EV_WRITE && e.kind == EV_WRITE) begin
            check("wr_addr", 64'(a), 64'(e.addr));
            check("wr_data", 64'(d), 64'(e.data));
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            run_len = 0;
        end else begin
            if (drawer_start) observe(EV_START, '0, '0);
            if (world_we)     observe(EV_WRITE, world_addr, world_wdata);
            if (edit_fail)    observe(EV_FAIL, '0, '0);
            if (fb_swap)      observe(EV_SWAP, '0, '0);
            if (busy) run_len++;
            else if (run_len != 0) begin
                last_len = run_len;
                run_len  = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic load_img();
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!busy) break;
            cyc();
        end
        check("frame_end_busy", 64'(busy), 64'd0);
    endtask

    // One frame: tick, clear checks, optional break during DRAW, done, finish.
    task automatic run_frame(input bit poke_tick, input bit break_in_draw, input bit swap_next);
        int cnt;
        cnt = 0;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!fb_clear_we) break;
            check("clear_addr", 64'(fb_clear_addr), 64'(cnt));
            if (drawer_start) check("start_at_last", 64'(cnt), 64'(FBW*FBH-1));
            frame_tick = poke_tick && (cnt == 5);
            cnt++;
            cyc();
        end
        frame_tick = 1'b0;
        check("clear_cycles", 64'(cnt), 64'(FBW*FBH));
        check("draw_busy", 64'(busy), 64'd1);
        check("draw_mux", 64'(world_addr), 64'(drawer_addr));
        if (break_in_draw) begin
            break_req = 1'b1;
            cyc();
            break_req = 1'b0;
        end
        drawer_done = 1'b1;
        cyc();
        drawer_done = 1'b0;
        if (swap_next) check("swap_after_done", 64'(fb_swap), 64'd1);
        wait_idle(400);
        cyc();
`ifdef FRAME_STATS_EN
        check("frame_cycles", 64'(frame_cycles), 64'(last_len));
`else
        check("frame_cycles", 64'(frame_cycles), 64'd0);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n_in = 1'b0;
        frame_tick = 1'b0;
        break_req = 1'b0;
        place_req = 1'b0;
        drawer_done = 1'b0;
        load = 1'b0;
        drawer_addr = 7'd42;
        looked_at_cube = '1;
        looked_at_normal = '0;
        for (int i = 0; i < WS; i++) img[i] = '0;
        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_clear_we", 64'(fb_clear_we), 64'd0);
        check("rst_clear_addr", 64'(fb_clear_addr), 64'd0);
        check("rst_world_we", 64'(world_we), 64'd0);
        check("rst_world_addr", 64'(world_addr), 64'd0);
        check("rst_pulses", 64'({drawer_start, fb_swap, edit_fail}), 64'd0);
        check("rst_frame_cycles", 64'(frame_cycles), 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cyc();

        // Empty frame.
        push(EV_START, '0, '0); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b0, 1'b1);

        // Break requested during DRAW, target 5.
        for (int i = 0; i < WS; i++) img[i] = (i < 10) ? mk(1'b1, i, i, i) : '0;
        load_img();
        looked_at_cube = 7'd5;
        push(EV_START, '0, '0); push(EV_WRITE, 7'd5, '0); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b1, 1'b0);

        // Place next to (10,0,7) with normal (-1,0,0); entry 4 is first free.
        for (int i = 0; i < WS; i++) img[i] = (i < 3) ? mk(1'b1, i, 1, 2) : '0;
        img[3] = mk(1'b1, 10, 0, 7);
        load_img();
        looked_at_cube = 7'd3;
        looked_at_normal = {2'b11, 2'b00, 2'b00};
        place_req = 1'b1; cyc(); place_req = 1'b0;
        push(EV_START, '0, '0); push(EV_WRITE, 7'd4, mk(1'b1, 9, 0, 7)); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b0, 1'b0);

        // Place with wrap-around coordinates; first free slot 50.
        for (int i = 0; i < WS; i++) img[i] = (i < 50) ? mk(1'b1, i, 3, 4) : '0;
        img[3] = mk(1'b1, 0, 65535, 5);
        load_img();
        looked_at_normal = {2'b11, 2'b01, 2'b01};
        place_req = 1'b1; cyc(); place_req = 1'b0;
        push(EV_START, '0, '0); push(EV_WRITE, 7'd50, mk(1'b1, 65535, 0, 6)); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b0, 1'b0);

        // World full: place dropped with edit_fail, swap still issued.
        for (int i = 0; i < WS; i++) img[i] = mk(1'b1, i, 0, 0);
        load_img();
        place_req = 1'b1; cyc(); place_req = 1'b0;
        push(EV_START, '0, '0); push(EV_FAIL, '0, '0); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b0, 1'b0);

        // Break and place in the same cycle: break wins at target 7.
        looked_at_cube = 7'd7;
        break_req = 1'b1; place_req = 1'b1; cyc(); break_req = 1'b0; place_req = 1'b0;
        push(EV_START, '0, '0); push(EV_WRITE, 7'd7, '0); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b0, 1'b0);

        // Tick during CLEAR ignored; break with no target discarded.
        looked_at_cube = '1;
        break_req = 1'b1; cyc(); break_req = 1'b0;
        push(EV_START, '0, '0); push(EV_SWAP, '0, '0);
        run_frame(1'b1, 1'b0, 1'b1);
        repeat (3) cyc();
        check("tick_ignored", 64'(busy), 64'd0);

        // Pending break was cleared: a targeted frame with no request writes nothing.
        looked_at_cube = 7'd5;
        push(EV_START, '0, '0); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b0, 1'b1);

        // Reset in the middle of CLEAR.
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        repeat (6) cyc();
        check("pre_reset_addr", 64'(fb_clear_addr), 64'd6);
        #2 rst_n_in = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_clear_we", 64'(fb_clear_we), 64'd0);
        check("async_rst_clear_addr", 64'(fb_clear_addr), 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cyc();
        push(EV_START, '0, '0); push(EV_SWAP, '0, '0);
        run_frame(1'b0, 1'b0, 1'b1);

        repeat (4) cyc();
        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
